// File: rtl/mct.sv
// ============================================================================
// Module   : mct
// Purpose  : Byte-serial memory controller; data-side loads/stores and 4-byte
//            instruction fetches share one byte-wide RAM port.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mct (
   input  logic        clk,
   input  logic        rst,
   input  logic        mm_mct_e,
   input  logic [31:0] mm_mct_a,
   input  logic        mm_mct_wr,
   input  logic [1:0]  mm_mct_cu,
   input  logic [31:0] mm_mct_n_i,
   output logic        mm_mct_ok,
   output logic [31:0] mm_mct_n_o,
   input  logic        if_e,
   input  logic [31:0] if_a,
   output logic        if_ok,
   output logic [31:0] if_n_o,
   output logic [31:0] ram_a,
   output logic        ram_wr,
   output logic [7:0]  ram_dout,
   input  logic [7:0]  ram_din
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MRD  = 3'd1,
      S_MWR  = 3'd2,
      S_IRD  = 3'd3,
      S_MFIN = 3'd4,
      S_IFIN = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic [1:0]  r_size;
   logic [23:0] r_cap;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (mm_mct_e)
               w_next = mm_mct_wr ? S_MWR : S_MRD;
            else if (if_e)
               w_next = S_IRD;
         end
         S_MRD, S_MWR: begin
            if (r_cnt == r_size)
               w_next = S_MFIN;
         end
         // A dropped fetch request is a flush and wins over completion
         S_IRD: begin
            if (!if_e)
               w_next = S_IDLE;
            else if (r_cnt == 2'd3)
               w_next = S_IFIN;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 2'd0;
         r_addr  <= 32'd0;
         r_data  <= 32'd0;
         r_size  <= 2'd0;
         r_cap   <= 24'd0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (mm_mct_e) begin
                  r_addr <= mm_mct_a;
                  r_data <= mm_mct_n_i;
                  r_size <= mm_mct_cu;
                  r_cnt  <= 2'd0;
                  r_cap  <= 24'd0;
               end else if (if_e) begin
                  r_addr <= if_a;
                  r_cnt  <= 2'd0;
                  r_cap  <= 24'd0;
               end
            end
            // RAM read data lags its address by one cycle
            S_MRD, S_IRD: begin
               r_cnt <= r_cnt + 2'd1;
               case (r_cnt)
                  2'd1:    r_cap[7:0]   <= ram_din;
                  2'd2:    r_cap[15:8]  <= ram_din;
                  2'd3:    r_cap[23:16] <= ram_din;
                  default: ;
               endcase
            end
            S_MWR: r_cnt <= r_cnt + 2'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      mm_mct_ok  = 1'b0;
      mm_mct_n_o = 32'd0;
      if_ok      = 1'b0;
      if_n_o     = 32'd0;
      ram_a      = 32'd0;
      ram_wr     = 1'b0;
      ram_dout   = 8'd0;
      case (r_state)
         S_MRD, S_IRD: ram_a = r_addr + {30'd0, r_cnt};
         S_MWR: begin
            ram_a  = r_addr + {30'd0, r_cnt};
            ram_wr = 1'b1;
            case (r_cnt)
               2'd0:    ram_dout = r_data[7:0];
               2'd1:    ram_dout = r_data[15:8];
               2'd2:    ram_dout = r_data[23:16];
               default: ram_dout = r_data[31:24];
            endcase
         end
         S_MFIN: begin
            mm_mct_ok  = 1'b1;
            mm_mct_n_o = {8'd0, r_cap};
         end
         S_IFIN: begin
            if_ok  = 1'b1;
            if_n_o = {ram_din, r_cap};
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_mct.sv
// ============================================================================
// Module   : tb_mct
// Purpose  : Randomized self-checking bench for mct with a transaction-level
//            memory model and per-cycle output comparison.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mct;

   logic        clk;
   logic        rst;
   logic        mm_e;
   logic [31:0] mm_a;
   logic        mm_wr;
   logic [1:0]  mm_cu;
   logic [31:0] mm_n_i;
   logic        mm_ok;
   logic [31:0] mm_n_o;
   logic        if_e;
   logic [31:0] if_a;
   logic        if_ok;
   logic [31:0] if_n_o;
   logic [31:0] ram_a;
   logic        ram_wr;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mct dut (
      .clk        (clk),
      .rst        (rst),
      .mm_mct_e   (mm_e),
      .mm_mct_a   (mm_a),
      .mm_mct_wr  (mm_wr),
      .mm_mct_cu  (mm_cu),
      .mm_mct_n_i (mm_n_i),
      .mm_mct_ok  (mm_ok),
      .mm_mct_n_o (mm_n_o),
      .if_e       (if_e),
      .if_a       (if_a),
      .if_ok      (if_ok),
      .if_n_o     (if_n_o),
      .ram_a      (ram_a),
      .ram_wr     (ram_wr),
      .ram_dout   (ram_dout),
      .ram_din    (ram_din)
   );

   // Physical RAM (written by the DUT) and the bench's golden memory image
   bit [7:0] ram  [bit [31:0]];
   bit [7:0] gmem [bit [31:0]];

   function automatic bit [7:0] pat(input bit [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
   endfunction

   function automatic bit [7:0] ram_rd(input bit [31:0] a);
      return ram.exists(a) ? ram[a] : pat(a);
   endfunction

   function automatic bit [7:0] gread(input bit [31:0] a);
      return gmem.exists(a) ? gmem[a] : pat(a);
   endfunction

   always @(posedge clk) begin
      ram_din <= ram_rd(ram_a);
      if (ram_wr) ram[ram_a] = ram_dout;
   end

   logic [31:0] exp_ram_a, exp_mm_n, exp_if_n;
   logic        exp_ram_wr, exp_mm_ok, exp_if_ok, exp_last_chk;
   logic [7:0]  exp_ram_dout, exp_last;
   bit          chk_en;
   int          checks;
   int          errors;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   task automatic exp_idle();
      exp_ram_a    = 32'd0;
      exp_ram_wr   = 1'b0;
      exp_ram_dout = 8'd0;
      exp_mm_ok    = 1'b0;
      exp_mm_n     = 32'd0;
      exp_if_ok    = 1'b0;
      exp_if_n     = 32'd0;
      exp_last_chk = 1'b0;
      exp_last     = 8'd0;
   endtask

   always @(negedge clk) begin
      if (chk_en && rst) begin
         chk("ram_a",    ram_a,          exp_ram_a);
         chk("ram_wr",   32'(ram_wr),    32'(exp_ram_wr));
         chk("ram_dout", 32'(ram_dout),  32'(exp_ram_dout));
         chk("mm_ok",    32'(mm_ok),     32'(exp_mm_ok));
         chk("if_ok",    32'(if_ok),     32'(exp_if_ok));
         if (exp_mm_ok) chk("mm_n_o", mm_n_o, exp_mm_n);
         if (exp_if_ok) chk("if_n_o", if_n_o, exp_if_n);
         if (exp_last_chk) chk("load_last_byte", 32'(ram_din), 32'(exp_last));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      exp_idle();
   endtask

   task automatic preload(input bit [31:0] a, input bit [7:0] b);
      ram[a]  = b;
      gmem[a] = b;
   endtask

   // Each op is entered positioned inside an IDLE cycle and returns inside its
   // last busy cycle; the caller steps once between ops.
   task automatic idle_op();
      mm_e = 1'b0;
      if_e = 1'b0;
   endtask

   task automatic data_op(input bit w, input bit [1:0] cu, input bit [31:0] a,
                          input bit [31:0] d, input bit with_fetch);
      int n;
      n      = int'(cu) + 1;
      mm_e   = 1'b1;
      mm_a   = a;
      mm_wr  = w;
      mm_cu  = cu;
      mm_n_i = d;
      if_e   = with_fetch;
      if_a   = $urandom;
      for (int k = 0; k < n; k++) begin
         step();
         exp_ram_a    = a + 32'(k);
         exp_ram_wr   = w;
         exp_ram_dout = w ? d[8*k +: 8] : 8'h00;
         if (w) gmem[a + 32'(k)] = d[8*k +: 8];
         mm_a   = $urandom;
         mm_n_i = $urandom;
         mm_wr  = 1'($urandom);
         mm_cu  = 2'($urandom);
      end
      step();
      exp_mm_ok = 1'b1;
      exp_mm_n  = 32'd0;
      if (!w) begin
         for (int k = 0; k < n - 1; k++) exp_mm_n[8*k +: 8] = gread(a + 32'(k));
         exp_last_chk = 1'b1;
         exp_last     = gread(a + 32'(n - 1));
      end
   endtask

   task automatic fetch_op(input bit [31:0] a, input int flush_at);
      mm_e = 1'b0;
      if_e = 1'b1;
      if_a = a;
      for (int m = 1; m <= 4; m++) begin
         step();
         exp_ram_a = a + 32'(m - 1);
         if_a      = $urandom;
         if (m == flush_at) begin
            if_e = 1'b0;
            return;
         end
      end
      step();
      exp_if_ok = 1'b1;
      exp_if_n  = {gread(a + 32'd3), gread(a + 32'd2), gread(a + 32'd1), gread(a)};
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached with %0d checks done", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      chk_en = 1'b0;
      exp_idle();
      rst    = 1'b1;
      mm_e   = 1'b0;
      mm_a   = 32'd0;
      mm_wr  = 1'b0;
      mm_cu  = 2'd0;
      mm_n_i = 32'd0;
      if_e   = 1'b0;
      if_a   = 32'd0;
      preload(32'h100, 8'h11);
      preload(32'h101, 8'h22);
      preload(32'h102, 8'h33);
      preload(32'h103, 8'h44);
      preload(32'h22,  8'h77);
      preload(32'h80,  8'h01);
      preload(32'h81,  8'h02);
      preload(32'h82,  8'h03);
      preload(32'h83,  8'h04);
      #1 rst = 1'b0;
      #2;
      chk("reset_ram_a",  ram_a,              32'd0);
      chk("reset_ram_wr", 32'(ram_wr),        32'd0);
      chk("reset_oks",    32'({mm_ok, if_ok}), 32'd0);
      #8;
      rst    = 1'b1;
      chk_en = 1'b1;

      // Word load accepted on the very first edge out of reset
      data_op(1'b0, 2'd3, 32'h100, 32'd0, 1'b0);
      chk("word_load_n_o", mm_n_o, 32'h0033_2211);
      chk("word_load_din", 32'(ram_din), 32'h44);

      step();
      data_op(1'b1, 2'd1, 32'h20, 32'hDEAD_BEEF, 1'b0);
      chk("half_store_b0",  32'(ram_rd(32'h20)), 32'hEF);
      chk("half_store_b1",  32'(ram_rd(32'h21)), 32'hBE);
      chk("half_store_b2",  32'(ram_rd(32'h22)), 32'h77);
      chk("store_n_o_zero", mm_n_o, 32'd0);

      step();
      data_op(1'b0, 2'd0, 32'h100, 32'd0, 1'b1);
      step();
      fetch_op(32'h80, 0);
      chk("fetch_word", if_n_o, 32'h0403_0201);

      step();
      fetch_op(32'h40, 2);
      step();
      idle_op();
      step();
      data_op(1'b0, 2'd0, 32'h40, 32'd0, 1'b0);

      step();
      data_op(1'b0, 2'd3, 32'hFFFF_FFFE, 32'd0, 1'b0);

      // Reset while the second byte of a word store is on the bus
      step();
      mm_e   = 1'b1;
      mm_a   = 32'h300;
      mm_wr  = 1'b1;
      mm_cu  = 2'd3;
      mm_n_i = 32'hA1B2_C3D4;
      if_e   = 1'b0;
      step();
      exp_ram_a = 32'h300; exp_ram_wr = 1'b1; exp_ram_dout = 8'hD4;
      gmem[32'h300] = 8'hD4;
      step();
      exp_ram_a = 32'h301; exp_ram_wr = 1'b1; exp_ram_dout = 8'hC3;
      #1 rst = 1'b0;
      mm_e = 1'b0;
      #1;
      chk("midrst_ram_a",    ram_a,            32'd0);
      chk("midrst_ram_wr",   32'(ram_wr),      32'd0);
      chk("midrst_ram_dout", 32'(ram_dout),    32'd0);
      exp_idle();
      repeat (2) @(posedge clk);
      #1 chk("midrst_no_ok", 32'({mm_ok, if_ok}), 32'd0);
      @(negedge clk);
      #1 rst = 1'b1;
      data_op(1'b0, 2'd3, 32'h300, 32'd0, 1'b0);
      chk("post_rst_load", {ram_din, mm_n_o[23:0]},
          {pat(32'h303), pat(32'h302), pat(32'h301), 8'hD4});

      for (int it = 0; it < 250; it++) begin
         int sel;
         step();
         sel = int'($urandom_range(0, 5));
         case (sel)
            0: idle_op();
            1, 2: data_op(1'($urandom), 2'($urandom), 32'h200 + $urandom_range(0, 23),
                          $urandom, 1'b0);
            3: fetch_op(32'h200 + $urandom_range(0, 23),
                        ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
            4: begin
               data_op(1'($urandom), 2'($urandom), 32'h200 + $urandom_range(0, 23),
                       $urandom, 1'b1);
               step();
               fetch_op(32'h200 + $urandom_range(0, 23), 0);
            end
            default: data_op(1'($urandom), 2'($urandom), 32'hFFFF_FFFC + $urandom_range(0, 3),
                             $urandom, 1'b0);
         endcase
      end
      step();
      idle_op();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
